// File: rtl/vram_arbiter_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared definitions for the video RAM arbiter:
//   - default geometry and arbitration parameters
//   - CPU-side state encoding (2 bits)
//   - helper that sizes the CPU wait counter
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

  localparam int DEF_A       = 14;  // address bits, depth = 2**A words
  localparam int DEF_D       = 8;   // data bits
  localparam int DEF_STEP    = 1;   // pointer increment per CPU access
  localparam int DEF_MAXWAIT = 16;  // denied cycles before a CPU access is forced

  // CPU client states.
  //   FETCH : read-ahead of mem[ptr] waiting for an array slot
  //   FLAND : read-ahead data arriving from the array output register
  //   IDLE  : buffer holds mem[ptr], ready to serve a read immediately
  //   WRITE : write of the latched data waiting for an array slot
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FLAND = 2'd1,
    ST_IDLE  = 2'd2,
    ST_WRITE = 2'd3
  } cpu_state_t;

  // Width of a counter that must reach maxwait; at least one bit so the
  // register stays legal when the starvation guard is disabled (maxwait = 0).
  function automatic int waitcnt_width(input int maxwait);
    if (maxwait < 1) begin
      return 1;
    end
    return $clog2(maxwait + 1);
  endfunction

endpackage

// File: rtl/vram_arbiter_ram_sp_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ram_sp_sync
// Single-port synchronous RAM, read-first, with a registered output.
// The output register is cleared by the asynchronous reset; the array itself
// is never reset.
//
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-high reset (output register only)
//   i_we     write enable for the addressed word
//   i_addr   word address (A bits)
//   i_wdata  write data (D bits)
//   o_dout   registered read data of the word addressed one edge earlier
// -----------------------------------------------------------------------------
module ram_sp_sync #(
  parameter int A = 14,
  parameter int D = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_we,
  input  logic [A-1:0] i_addr,
  input  logic [D-1:0] i_wdata,
  output logic [D-1:0] o_dout
);

  logic [D-1:0] r_mem [0:(1<<A)-1];
  logic [D-1:0] r_dout;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read-first: a write cycle returns the previous contents of the word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dout <= '0;
    end else begin
      r_dout <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/vram_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vram_arbiter
// One video RAM array shared by two clients:
//   - video fetch: priority client, fixed one-cycle read latency
//   - CPU: auto-incrementing pointer, one-word read-ahead buffer and a
//     req/ack handshake; a starvation guard forces a CPU access after
//     MAXWAIT denied cycles (MAXWAIT = 0 disables forcing).
//
// Ports:
//   i_clk        clock
//   i_reset      asynchronous active-high reset
//   i_vid_en     video read request this cycle
//   i_vid_addr   video read address
//   o_vid_data   video read data (straight from the array output register)
//   o_vid_valid  o_vid_data holds the result of i_vid_en one edge earlier
//   i_cpu_ld     load pointer from i_cpu_addr (ignored while o_cpu_busy)
//   i_cpu_addr   new pointer value
//   i_cpu_req    CPU access request, held until o_cpu_ack
//   i_cpu_we     1 = write, 0 = read; qualifies i_cpu_req
//   i_cpu_wdata  write data
//   o_cpu_rdata  read data, valid with o_cpu_ack and held afterwards
//   o_cpu_ack    one-cycle completion pulse
//   o_cpu_busy   high while a write is pending
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int A       = DEF_A,
  parameter int D       = DEF_D,
  parameter int STEP    = DEF_STEP,
  parameter int MAXWAIT = DEF_MAXWAIT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_vid_en,
  input  logic [A-1:0] i_vid_addr,
  output logic [D-1:0] o_vid_data,
  output logic         o_vid_valid,
  input  logic         i_cpu_ld,
  input  logic [A-1:0] i_cpu_addr,
  input  logic         i_cpu_req,
  input  logic         i_cpu_we,
  input  logic [D-1:0] i_cpu_wdata,
  output logic [D-1:0] o_cpu_rdata,
  output logic         o_cpu_ack,
  output logic         o_cpu_busy
);

  localparam int              WW     = waitcnt_width(MAXWAIT);
  localparam logic [WW-1:0]   WMAX   = WW'(MAXWAIT);
  localparam logic [A-1:0]    STEP_A = A'(STEP);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  cpu_state_t    r_state;
  logic [A-1:0]  r_ptr;
  logic [D-1:0]  r_buf;
  logic [D-1:0]  r_wdata;
  logic [D-1:0]  r_cpu_rdata;
  logic          r_cpu_ack;
  logic          r_vid_valid;
  logic [WW-1:0] r_waitcnt;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic          w_cpu_pending;
  logic          w_force;
  logic          w_cpu_grant;
  logic          w_req_take;
  logic          w_ram_we;
  logic [A-1:0]  w_ram_addr;
  logic [D-1:0]  w_ram_dout;

  // Only FETCH and WRITE need an array slot; FLAND and IDLE never compete.
  assign w_cpu_pending = (r_state == ST_FETCH) || (r_state == ST_WRITE);
  assign w_force       = (MAXWAIT != 0) && (r_waitcnt == WMAX);
  assign w_cpu_grant   = w_cpu_pending && (!i_vid_en || w_force);

  // The ack cycle is the tail of the previous transaction; a request still
  // held high in that cycle must not start a second one.
  assign w_req_take    = i_cpu_req && !r_cpu_ack;

  assign w_ram_we      = w_cpu_grant && (r_state == ST_WRITE);
  assign w_ram_addr    = w_cpu_grant ? r_ptr : i_vid_addr;

  ram_sp_sync #(
    .A (A),
    .D (D)
  ) u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_dout  (w_ram_dout)
  );

  // ---------------------------------------------------------------------------
  // CPU state machine, wait counter and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_FETCH;
      r_ptr       <= '0;
      r_buf       <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_waitcnt   <= '0;
    end else begin
      r_cpu_ack   <= 1'b0;

      // A forced cycle steals the array from video, so that read is lost.
      r_vid_valid <= i_vid_en && !w_force;

      // Count consecutive denied cycles of a pending CPU access. Saturating
      // keeps the counter at zero when forcing is disabled.
      if (w_cpu_pending && !w_cpu_grant) begin
        if (r_waitcnt != WMAX) begin
          r_waitcnt <= r_waitcnt + 1'b1;
        end
      end else begin
        r_waitcnt <= '0;
      end

      case (r_state)
        ST_FETCH: begin
          // A pointer load restarts the read-ahead at the new address.
          if (i_cpu_ld) begin
            r_ptr <= i_cpu_addr;
          end else if (w_cpu_grant) begin
            r_state <= ST_FLAND;
          end
        end

        ST_FLAND: begin
          // The array output register now holds mem[ptr] from the granted
          // FETCH cycle; a pointer load discards it instead.
          if (i_cpu_ld) begin
            r_ptr   <= i_cpu_addr;
            r_state <= ST_FETCH;
          end else begin
            r_buf   <= w_ram_dout;
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (i_cpu_ld) begin
            r_ptr   <= i_cpu_addr;
            r_state <= ST_FETCH;
          end else if (w_req_take) begin
            if (i_cpu_we) begin
              r_wdata <= i_cpu_wdata;
              r_state <= ST_WRITE;
            end else begin
              // Reads are served from the read-ahead buffer without
              // touching the array.
              r_cpu_rdata <= r_buf;
              r_cpu_ack   <= 1'b1;
              r_ptr       <= r_ptr + STEP_A;
              r_state     <= ST_FETCH;
            end
          end
        end

        ST_WRITE: begin
          // Pointer loads are ignored until the write lands.
          if (w_cpu_grant) begin
            r_cpu_ack <= 1'b1;
            r_ptr     <= r_ptr + STEP_A;
            r_state   <= ST_FETCH;
          end
        end

        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign o_vid_data  = w_ram_dout;
  assign o_vid_valid = r_vid_valid;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_busy  = (r_state == ST_WRITE);

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;

  // DUT 1: MAXWAIT = 4
  logic        vid_en;
  logic [13:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_ld;
  logic [13:0] cpu_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;

  // DUT 2: MAXWAIT = 0 (video has absolute priority)
  logic        vid_en2;
  logic [7:0]  vid_data2;
  logic        vid_valid2;
  logic        req2;
  logic        we2;
  logic [7:0]  wd2;
  logic [7:0]  rdata2;
  logic        ack2;
  logic        busy2;

  always #5 clk = ~clk;

  vram_arbiter #(.A(14), .D(8), .STEP(1), .MAXWAIT(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_vid_en    (vid_en),
    .i_vid_addr  (vid_addr),
    .o_vid_data  (vid_data),
    .o_vid_valid (vid_valid),
    .i_cpu_ld    (cpu_ld),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_busy  (cpu_busy)
  );

  vram_arbiter #(.A(14), .D(8), .STEP(1), .MAXWAIT(0)) dut2 (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_vid_en    (vid_en2),
    .i_vid_addr  (14'h0000),
    .o_vid_data  (vid_data2),
    .o_vid_valid (vid_valid2),
    .i_cpu_ld    (1'b0),
    .i_cpu_addr  (14'h0000),
    .i_cpu_req   (req2),
    .i_cpu_we    (we2),
    .i_cpu_wdata (wd2),
    .o_cpu_rdata (rdata2),
    .o_cpu_ack   (ack2),
    .o_cpu_busy  (busy2)
  );

  int checks = 0;
  int errors = 0;
  int vid_drops = 0;
  int exp_ptr = 0;

  typedef struct {
    bit         is_read;
    logic [7:0] data;
  } cpu_exp_t;

  cpu_exp_t   cpu_q[$];
  logic [7:0] vid_q[$];
  logic [7:0] model [int];
  cpu_exp_t   mon_e;
  logic [7:0] mon_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Video scoreboard: every sampled vid_en expects model data one edge later.
  always @(posedge clk) begin
    if (!rst && vid_en) begin
      vid_q.push_back(model[int'(vid_addr)]);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst) begin
      cpu_q.delete();
      vid_q.delete();
    end else begin
      if (cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_ack_unexpected: got ack with rdata 0x%0h, expected no ack", cpu_rdata);
        end else begin
          mon_e = cpu_q.pop_front();
          if (mon_e.is_read) begin
            chk("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.data));
            $display("[%0t] cpu read ack rdata=0x%02h exp=0x%02h", $time, cpu_rdata, mon_e.data);
          end else begin
            $display("[%0t] cpu write ack", $time);
          end
        end
      end
      if (vid_q.size() != 0) begin
        mon_v = vid_q.pop_front();
        if (vid_valid) begin
          chk("vid_data", 32'(vid_data), 32'(mon_v));
        end else begin
          vid_drops++;
          $display("[%0t] video read dropped", $time);
        end
      end else if (vid_valid) begin
        checks++;
        errors++;
        $display("FAIL vid_valid_spurious: got vid_valid=1, expected 0");
      end
    end
  end

  task automatic wait_ack(input int max, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack && lat < max);
    checks++;
    if (!cpu_ack) begin
      errors++;
      $display("FAIL ack_timeout: no cpu_ack after %0d cycles, expected within bound", lat);
    end
  endtask

  task automatic do_ld(input int a);
    cpu_ld   = 1'b1;
    cpu_addr = 14'(a);
    tick();
    cpu_ld   = 1'b0;
    exp_ptr  = a;
  endtask

  // Settle into IDLE, issue one CPU access and check its latency.
  task automatic cpu_op(input bit we, input logic [7:0] wd, input int exp_lat, input string name);
    cpu_exp_t e;
    int lat;
    repeat (3) tick();
    e.is_read = !we;
    e.data    = we ? 8'h00 : model[exp_ptr];
    if (we) model[exp_ptr] = wd;
    cpu_q.push_back(e);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_wdata = wd;
    wait_ack(300, lat);
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    exp_ptr   = (exp_ptr + 1) & 32'h3FFF;
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    int invalid2;
    int drops_before;

    rst = 1'b1;
    vid_en = 0; vid_addr = '0; cpu_ld = 0; cpu_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_wdata = '0;
    vid_en2 = 0; req2 = 0; we2 = 0; wd2 = '0;
    repeat (2) tick();

    // Reset values
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_vid_data",  32'(vid_data),  32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    chk("rst_cpu_busy",  32'(cpu_busy),  32'd0);
    chk("rst_ptr",       32'(dut.r_ptr), 32'd0);
    chk("rst_waitcnt",   32'(dut.r_waitcnt), 32'd0);
    chk("rst_state",     32'(dut.r_state), 32'(ST_FETCH));
    rst = 1'b0;
    exp_ptr = 0;

    // Seed mem[0], reset again (array keeps contents), read it back.
    cpu_op(1'b1, 8'h3C, 2, "wr_addr0");
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_ptr = 0;
    cpu_op(1'b0, 8'h00, 1, "rd_addr0");
    chk("ptr_after_rd0", 32'(dut.r_ptr), 32'd1);

    // Two writes then read back through a reloaded pointer.
    do_ld(32'h0100);
    cpu_op(1'b1, 8'hA5, 2, "wr_100");
    cpu_op(1'b1, 8'h5A, 2, "wr_101");
    do_ld(32'h0100);
    cpu_op(1'b0, 8'h00, 1, "rd_100");
    cpu_op(1'b0, 8'h00, 1, "rd_101");
    chk("ptr_after_rd101", 32'(dut.r_ptr), 32'h0102);

    // Video reads at several addresses (CPU read-ahead pending, not forced).
    vid_en = 1'b1; vid_addr = 14'h0100; tick();
    vid_addr = 14'h0101; tick();
    vid_addr = 14'h0000; tick();
    vid_en = 1'b0; tick();

    // Contention with MAXWAIT = 4: 4 denied cycles, forced write on the 5th.
    do_ld(32'h0200);
    repeat (3) tick();
    vid_en = 1'b1; vid_addr = 14'h0100;
    drops_before = vid_drops;
    cpu_op(1'b1, 8'h77, 6, "wr_forced");
    vid_en = 1'b0;
    chk("waitcnt_after_force", 32'(dut.r_waitcnt), 32'd0);
    tick();
    chk("forced_vid_drops", 32'(vid_drops - drops_before), 32'd1);
    do_ld(32'h0200);
    cpu_op(1'b0, 8'h00, 1, "rd_200");

    // Pointer wrap at the top of the array.
    do_ld(32'h3FFF);
    cpu_op(1'b1, 8'hEE, 2, "wr_3fff");
    chk("ptr_wrap_wr", 32'(dut.r_ptr), 32'd0);
    do_ld(32'h3FFF);
    cpu_op(1'b0, 8'h00, 1, "rd_3fff");
    cpu_op(1'b0, 8'h00, 1, "rd_wrap0");
    chk("ptr_wrap_rd", 32'(dut.r_ptr), 32'd1);

    // Pointer load during FLAND discards the read-ahead.
    do_ld(32'h0100);
    cpu_op(1'b0, 8'h00, 1, "rd_100_b");
    tick();
    chk("state_is_fland", 32'(dut.r_state), 32'(ST_FLAND));
    do_ld(32'h0200);
    cpu_op(1'b0, 8'h00, 1, "rd_after_fland_ld");

    // Pointer load during WRITE is ignored.
    do_ld(32'h0300);
    repeat (3) tick();
    vid_en = 1'b1; vid_addr = 14'h0101;
    mon_e.is_read = 1'b0; mon_e.data = 8'h00;
    cpu_q.push_back(mon_e);
    model[32'h0300] = 8'h55;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h55;
    tick();
    chk("busy_in_write", 32'(cpu_busy), 32'd1);
    cpu_ld = 1'b1; cpu_addr = 14'h0010;
    tick();
    cpu_ld = 1'b0;
    chk("ptr_ld_in_write", 32'(dut.r_ptr), 32'h0300);
    vid_en = 1'b0;
    wait_ack(20, lat);
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_300_lat", 32'(lat), 32'd1);
    chk("ptr_after_wr300", 32'(dut.r_ptr), 32'h0301);
    chk("busy_after_wr", 32'(cpu_busy), 32'd0);
    do_ld(32'h0300);
    cpu_op(1'b0, 8'h00, 1, "rd_300");

    // Reset while a write waits for its slot: memory unchanged.
    do_ld(32'h0400);
    cpu_op(1'b1, 8'h12, 2, "wr_400");
    do_ld(32'h0400);
    repeat (3) tick();
    vid_en = 1'b1; vid_addr = 14'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h34;
    repeat (2) tick();
    chk("state_write_pre_rst", 32'(dut.r_state), 32'(ST_WRITE));
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; vid_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_ptr = 0;
    chk("ptr_after_midwr_rst", 32'(dut.r_ptr), 32'd0);
    chk("busy_after_midwr_rst", 32'(cpu_busy), 32'd0);
    do_ld(32'h0400);
    cpu_op(1'b0, 8'h00, 1, "rd_400_unchanged");

    // MAXWAIT = 0 instance: video holds the array, CPU never forced.
    repeat (3) tick();
    req2 = 1'b1; we2 = 1'b1; wd2 = 8'h42;
    lat = 0;
    do begin tick(); lat++; end while (!ack2 && lat < 20);
    req2 = 1'b0; we2 = 1'b0;
    chk("d2_wr_lat", 32'(lat), 32'd2);
    repeat (3) tick();
    vid_en2 = 1'b1;
    req2 = 1'b1; we2 = 1'b1; wd2 = 8'h99;
    acks = 0; invalid2 = 0;
    repeat (100) begin
      tick();
      if (ack2) acks++;
      if (!vid_valid2) invalid2++;
    end
    chk("d2_no_ack_under_video", 32'(acks), 32'd0);
    chk("d2_no_video_drop", 32'(invalid2), 32'd0);
    chk("d2_waitcnt", 32'(dut2.r_waitcnt), 32'd0);
    vid_en2 = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!ack2 && lat < 20);
    req2 = 1'b0; we2 = 1'b0;
    chk("d2_ack_after_video_low", 32'(lat), 32'd1);
    chk("d2_ptr", 32'(dut2.r_ptr), 32'd2);

    repeat (2) tick();
    chk("cpu_scoreboard_empty", 32'(cpu_q.size()), 32'd0);
    chk("total_vid_drops", 32'(vid_drops), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
